// File: rtl/sobel_pkg.sv
// Shared definitions for the sobel frame sequencer: FSM encoding and frame-size helpers.
package sobel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    START,
    LOAD,
    WAIT_DONE
  } state_t;

  function automatic int n_pix(input int w, input int h);
    return w * h;
  endfunction

  // Valid 3x3 windows exclude a one-pixel border on every side.
  function automatic int n_out(input int w, input int h);
    return (w - 2) * (h - 2);
  endfunction

endpackage

// File: rtl/sobel_pix_fifo.sv
// Synchronous first-word-fall-through pixel FIFO; dout always shows the head entry.
module sobel_pix_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for sobel_filter: buffers input pixels, starts the filter, streams one
// pixel per cycle into it, counts outputs and flags underrun / count / timeout errors.
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int FIFO_DEPTH = 16,
  parameter int PRELOAD    = 16,
  parameter int TIMEOUT    = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_req,
  output logic             frame_ack,
  input  logic [WIDTH-1:0] s_pixel,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             flt_rst_n,
  output logic             flt_start,
  output logic [WIDTH-1:0] flt_pixel,
  input  logic [WIDTH-1:0] flt_pixel_out,
  input  logic             flt_valid,
  input  logic             flt_done,
  output logic [WIDTH-1:0] m_pixel,
  output logic             m_valid,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      frames_done,
  output logic             err_underrun,
  output logic             err_count,
  output logic             err_timeout,
  input  logic             err_clear
);

  localparam int N_PIX  = n_pix(IMG_WIDTH, IMG_HEIGHT);
  localparam int N_OUT  = n_out(IMG_WIDTH, IMG_HEIGHT);
  localparam int CNT_W  = $clog2(N_PIX + 1);
  localparam int WD_W   = $clog2(TIMEOUT + 1);
  localparam int FC_W   = $clog2(FIFO_DEPTH + 1);
  // A frame smaller than PRELOAD can start as soon as it is fully buffered.
  localparam int FILL_N = (PRELOAD < N_PIX) ? PRELOAD : N_PIX;

  localparam logic [CNT_W-1:0] LD_LAST = CNT_W'(N_PIX - 1);
  localparam logic [CNT_W-1:0] OUT_EXP = CNT_W'(N_OUT);
  localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT);
  localparam logic [FC_W-1:0]  FILL_TH = FC_W'(FILL_N);

  state_t            state, state_n;
  logic [CNT_W-1:0]  ld_cnt, out_cnt, out_cnt_nx;
  logic [WD_W-1:0]   wd_cnt;
  logic              pop, underrun, abort, done_hit, counting;
  logic [WIDTH-1:0]  fifo_dout;
  logic              fifo_full, fifo_empty;
  logic [FC_W-1:0]   fifo_cnt;

  sobel_pix_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (s_valid && s_ready),
    .din  (s_pixel),
    .pop  (pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_cnt)
  );

  always_comb begin
    state_n   = state;
    pop       = 1'b0;
    underrun  = 1'b0;
    abort     = 1'b0;
    done_hit  = 1'b0;
    flt_start = 1'b0;
    flt_pixel = '0;
    case (state)
      IDLE:  if (frame_req) state_n = FILL;
      FILL:  if (fifo_cnt >= FILL_TH) state_n = START;
      START: begin
        flt_start = 1'b1;
        state_n   = LOAD;
      end
      LOAD: begin
        // The load slot is consumed even when starved so pixel timing never slips.
        if (fifo_empty) underrun = 1'b1;
        else begin
          flt_pixel = fifo_dout;
          pop       = 1'b1;
        end
        if (ld_cnt == LD_LAST) state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (flt_done) begin
          done_hit = 1'b1;
          state_n  = IDLE;
        end else if (wd_cnt == WD_MAX) begin
          abort   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign counting   = (state == LOAD || state == WAIT_DONE) && (state_n != IDLE);
  // Include an output arriving in the same cycle as done.
  assign out_cnt_nx = out_cnt + CNT_W'(flt_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ld_cnt       <= '0;
      out_cnt      <= '0;
      wd_cnt       <= '0;
      frame_ack    <= 1'b0;
      frame_done   <= 1'b0;
      frames_done  <= '0;
      m_pixel      <= '0;
      m_valid      <= 1'b0;
      err_underrun <= 1'b0;
      err_count    <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state      <= state_n;
      frame_ack  <= (state == IDLE) && frame_req;
      frame_done <= done_hit;
      if (done_hit) frames_done <= frames_done + 16'd1;
      ld_cnt  <= (state == LOAD) ? ld_cnt + CNT_W'(1) : '0;
      out_cnt <= counting ? out_cnt_nx : '0;
      wd_cnt  <= (state == WAIT_DONE && state_n == WAIT_DONE) ? wd_cnt + WD_W'(1) : '0;
      m_pixel <= flt_pixel_out;
      m_valid <= flt_valid && !abort;
      err_underrun <= underrun | (err_underrun & ~err_clear);
      err_count    <= (done_hit && (out_cnt_nx != OUT_EXP)) | (err_count & ~err_clear);
      err_timeout  <= abort | (err_timeout & ~err_clear);
    end
  end

  assign s_ready   = !fifo_full && !rst;
  assign flt_rst_n = !rst && !abort;
  assign busy      = (state != IDLE);

endmodule
